// File: rtl/midi_pkg.sv
// Shared constants, state encodings and the note-to-period ROM for the MIDI note controller.
// Period table assumes a 50 MHz clock and a 256-entry wavetable.
package midi_pkg;

    localparam int unsigned CLK_HZ_DEF = 50_000_000;
    localparam int unsigned BAUD_DEF   = 31_250;
    localparam int unsigned TICKS_W    = 24;
    localparam int unsigned NOTE_W     = 7;
    localparam int unsigned MOD_W      = 8;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHPRESS  = 4'hD;

    localparam logic [NOTE_W-1:0] CC_MOD     = 7'd1;
    localparam logic [NOTE_W-1:0] CC_ALL_OFF = 7'd123;
    localparam logic [NOTE_W-1:0] RESET_NOTE = 7'd69;

    typedef enum logic [1:0] {
        PS_NO_STATUS,
        PS_DATA1,
        PS_DATA2
    } parse_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Lowest-octave wavetable step period in clock ticks, Q.8 fixed point.
    function automatic logic [23:0] semitone_q8(input logic [3:0] semi);
        logic [23:0] p;
        case (semi)
            4'd0:    p = 24'd6115610;
            4'd1:    p = 24'd5772367;
            4'd2:    p = 24'd5448389;
            4'd3:    p = 24'd5142595;
            4'd4:    p = 24'd4853963;
            4'd5:    p = 24'd4581531;
            4'd6:    p = 24'd4324390;
            4'd7:    p = 24'd4081680;
            4'd8:    p = 24'd3852593;
            4'd9:    p = 24'd3636364;
            4'd10:   p = 24'd3432270;
            4'd11:   p = 24'd3239632;
            default: p = 24'd0;
        endcase
        return p;
    endfunction

    // Each octave halves the period; round-to-nearest on the shift, then minus one.
    function automatic logic [TICKS_W-1:0] note_ticks(input logic [NOTE_W-1:0] note);
        logic [3:0]  oct;
        logic [3:0]  semi;
        logic [4:0]  sh;
        logic [31:0] p;
        oct  = 4'(note / 7'd12);
        semi = 4'(note % 7'd12);
        sh   = 5'(oct) + 5'd8;
        p    = {8'd0, semitone_q8(semi)} + (32'd1 << (sh - 5'd1));
        return TICKS_W'((p >> sh) - 32'd1);
    endfunction

endpackage

// File: rtl/midi_note_controller_if.sv
// Serial MIDI input plus the note/modulation controls handed to the Synthesizer.
interface midi_note_controller_if;
    import midi_pkg::*;

    logic                midiRx;
    logic                isNoteOn;
    logic [TICKS_W-1:0]  noteSampleTicks;
    logic [MOD_W-1:0]    modulationValue;
    logic [NOTE_W-1:0]   noteNumber;
    logic                rxError;

    modport slave (
        input  midiRx,
        output isNoteOn,
        output noteSampleTicks,
        output modulationValue,
        output noteNumber,
        output rxError
    );

    modport master (
        output midiRx,
        input  isNoteOn,
        input  noteSampleTicks,
        input  modulationValue,
        input  noteNumber,
        input  rxError
    );

endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, start-bit glitch rejection, centre sampling.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_valid_o,
    output logic       rx_error_o
);

    localparam int unsigned CNT_W = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_TICKS / 2 - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    // Synchronizers reset high so a released reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_byte_o  <= '0;
            rx_valid_o <= 1'b0;
            rx_error_o <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_valid_o <= 1'b0;
            rx_error_o <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (sync2_q) begin
                            rx_valid_o <= 1'b1;
                            rx_byte_o  <= shift_q;
                        end else begin
                            rx_error_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/midi_note_controller.sv
// MIDI byte parser with running status; drives monophonic note and mod-wheel controls.
module midi_note_controller
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
    parameter int unsigned BAUD         = BAUD_DEF,
    parameter int unsigned MIDI_CHANNEL = 0
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    midi_note_controller_if.slave   bus
);

    localparam int unsigned BIT_TICKS = CLK_HZ / BAUD;
    localparam logic        OMNI      = (MIDI_CHANNEL >= 16);
    localparam logic [3:0]  CHAN      = 4'(MIDI_CHANNEL % 16);
    localparam logic [TICKS_W-1:0] RESET_TICKS = note_ticks(RESET_NOTE);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;

    midi_uart_rx #(
        .BIT_TICKS (BIT_TICKS)
    ) u_uart (
        .clk        (CLOCK_50),
        .rst        (reset),
        .rx_i       (bus.midiRx),
        .rx_byte_o  (rx_byte),
        .rx_valid_o (rx_valid),
        .rx_error_o (rx_error)
    );

    parse_state_e        ps_q;
    logic [3:0]          status_q;
    logic                chan_ok_q;
    logic [NOTE_W-1:0]   data1_q;
    logic                note_on_q;
    logic [NOTE_W-1:0]   note_q;
    logic [TICKS_W-1:0]  ticks_q;
    logic [TICKS_W-1:0]  ticks_d;
    logic [MOD_W-1:0]    mod_q;

    logic       is_status;
    logic       is_realtime;
    logic       is_system;
    logic [6:0] data_val;

    assign is_status   = rx_byte[7];
    assign is_realtime = (rx_byte[7:3] == 5'b11111);
    assign is_system   = (rx_byte[7:4] == 4'hF);
    assign data_val    = rx_byte[6:0];

    always_comb begin
        ticks_d = note_ticks(data1_q);
    end

    // Parser: status latches persist across messages until a system byte clears them.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ps_q      <= PS_NO_STATUS;
            status_q  <= '0;
            chan_ok_q <= 1'b0;
            data1_q   <= '0;
            note_on_q <= 1'b0;
            note_q    <= RESET_NOTE;
            ticks_q   <= RESET_TICKS;
            mod_q     <= '0;
        end else if (rx_valid) begin
            if (is_status) begin
                if (!is_realtime) begin
                    if (is_system) begin
                        ps_q <= PS_NO_STATUS;
                    end else begin
                        status_q  <= rx_byte[7:4];
                        chan_ok_q <= OMNI || (rx_byte[3:0] == CHAN);
                        ps_q      <= PS_DATA1;
                    end
                end
            end else begin
                case (ps_q)
                    PS_DATA1: begin
                        data1_q <= data_val;
                        if (status_q == ST_PROG || status_q == ST_CHPRESS) begin
                            ps_q <= PS_DATA1;
                        end else begin
                            ps_q <= PS_DATA2;
                        end
                    end
                    PS_DATA2: begin
                        ps_q <= PS_DATA1;
                        if (chan_ok_q) begin
                            case (status_q)
                                ST_NOTE_ON: begin
                                    if (data_val != 7'd0) begin
                                        note_q    <= data1_q;
                                        ticks_q   <= ticks_d;
                                        note_on_q <= 1'b1;
                                    end else if (data1_q == note_q) begin
                                        note_on_q <= 1'b0;
                                    end
                                end
                                ST_NOTE_OFF: begin
                                    if (data1_q == note_q) begin
                                        note_on_q <= 1'b0;
                                    end
                                end
                                ST_CC: begin
                                    if (data1_q == CC_MOD) begin
                                        mod_q <= {data_val, 1'b0};
                                    end else if (data1_q == CC_ALL_OFF) begin
                                        note_on_q <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.isNoteOn        = note_on_q;
    assign bus.noteNumber      = note_q;
    assign bus.noteSampleTicks = ticks_q;
    assign bus.modulationValue = mod_q;
    assign bus.rxError         = rx_error;

endmodule
